// File: rtl/dsram_pkg.sv
// Shared types and constants for the data-SRAM responder slice.
package dsram_pkg;

  // Access size as presented by the requester; wstrb is what actually selects bytes.
  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } size_e;

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned AGE_W   = 4;
  localparam int unsigned LAT_MAX = 15;

  // One outstanding response: kind, captured read word, cycles since acceptance.
  typedef struct packed {
    logic              is_write;
    logic [DATA_W-1:0] data;
    logic [AGE_W-1:0]  age;
  } resp_entry_t;

  // Age advance that stops once the entry is due.
  function automatic logic [AGE_W-1:0] age_step(input logic [AGE_W-1:0] age,
                                                input logic [AGE_W-1:0] limit);
    return (age >= limit) ? age : age + AGE_W'(1);
  endfunction

endpackage

// File: rtl/dsram_responder_if.sv
// Request/response bus between the pipeline MEM stage and the data SRAM.
interface dsram_responder_if;
  logic                req;
  logic                wr;
  dsram_pkg::size_e    size;
  logic [3:0]          wstrb;
  logic [31:0]         addr;
  logic [31:0]         wdata;
  logic                addr_ok;
  logic                data_ok;
  logic [31:0]         rdata;

  modport master (
    output req, wr, size, wstrb, addr, wdata,
    input  addr_ok, data_ok, rdata
  );

  modport slave (
    input  req, wr, size, wstrb, addr, wdata,
    output addr_ok, data_ok, rdata
  );
endinterface

// File: rtl/dsram_resp_fifo.sv
// In-order response queue with a per-entry age counter; presents the head
// as a registered data_ok/rdata pair once it has aged LATENCY cycles.
module dsram_resp_fifo
  import dsram_pkg::*;
#(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned LATENCY = 2
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     push,
  input  logic                     push_is_write,
  input  logic [DATA_W-1:0]        push_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     out_valid,
  output logic [DATA_W-1:0]        out_data
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  // Ages are AGE_W bits wide, so the due age cannot exceed LAT_MAX.
  localparam logic [AGE_W-1:0] AGE_DONE =
    AGE_W'((LATENCY > LAT_MAX) ? LAT_MAX : LATENCY);

  resp_entry_t       ent [DEPTH];
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_nxt;
  logic [CNT_W-1:0]  remain;
  logic              pop;
  logic              head_ok_d;
  logic [DATA_W-1:0] head_data_d;

  // out_valid mirrors "head age == LATENCY" one edge early: look at whichever
  // entry will be head after this edge (possibly the one being pushed) and its
  // next age, so the response pulse itself comes straight from a flop.
  always_comb begin
    pop         = out_valid;
    rd_nxt      = rd_ptr + PTR_W'(pop);
    remain      = count - CNT_W'(pop);
    head_ok_d   = 1'b0;
    head_data_d = '0;
    if (remain != '0) begin
      head_ok_d   = (age_step(ent[rd_nxt].age, AGE_DONE) == AGE_DONE);
      head_data_d = ent[rd_nxt].is_write ? '0 : ent[rd_nxt].data;
    end else if (push) begin
      head_ok_d   = (AGE_DONE == AGE_W'(1));
      head_data_d = push_is_write ? '0 : push_data;
    end
  end

  // Pointers, occupancy and the registered response outputs.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      rd_ptr    <= rd_nxt;
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      count     <= count + CNT_W'(push) - CNT_W'(pop);
      out_valid <= head_ok_d;
      if (head_ok_d) out_data <= head_data_d;
    end
  end

  // Entry storage: load on push, otherwise every age advances (saturating).
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (push && (wr_ptr == PTR_W'(i))) begin
        ent[i] <= '{is_write: push_is_write, data: push_data, age: AGE_W'(1)};
      end else begin
        ent[i].age <= age_step(ent[i].age, AGE_DONE);
      end
    end
  end

endmodule

// File: rtl/dsram_responder.sv
// Behavioural data SRAM slave: byte-strobe writes, fixed-latency in-order
// responses, bounded number of outstanding requests.
module dsram_responder
  import dsram_pkg::*;
#(
  parameter int unsigned ADDR_W  = 10,
  parameter int unsigned LATENCY = 2,
  parameter int unsigned QDEPTH  = 4
) (
  input  logic               clk,
  input  logic               resetn,
  dsram_responder_if.slave   bus
);

  localparam int unsigned    CNT_W = $clog2(QDEPTH) + 1;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(QDEPTH);

  logic [DATA_W-1:0] mem [2**ADDR_W];
  logic [ADDR_W-1:0] widx;
  logic [DATA_W-1:0] rd_word;
  logic [CNT_W-1:0]  count;
  logic              accept;
  logic              data_ok_q;
  logic [DATA_W-1:0] rdata_q;
  logic              unused_bits;

  assign widx        = bus.addr[ADDR_W+1:2];
  assign rd_word     = mem[widx];
  assign bus.addr_ok = (count < FULL);
  assign accept      = bus.req && bus.addr_ok;
  assign bus.data_ok = data_ok_q;
  assign bus.rdata   = rdata_q;
  assign unused_bits = ^{bus.size, bus.addr[31:ADDR_W+2], bus.addr[1:0]};

  // Byte-lane merge of accepted writes; memory survives reset.
  always_ff @(posedge clk) begin
    if (accept && bus.wr) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (bus.wstrb[b]) mem[widx][8*b +: 8] <= bus.wdata[8*b +: 8];
      end
    end
  end

  dsram_resp_fifo #(
    .DEPTH   (QDEPTH),
    .LATENCY (LATENCY)
  ) u_fifo (
    .clk           (clk),
    .resetn        (resetn),
    .push          (accept),
    .push_is_write (bus.wr),
    .push_data     (rd_word),
    .count         (count),
    .out_valid     (data_ok_q),
    .out_data      (rdata_q)
  );

endmodule

// File: tb/tb_dsram_responder.sv
// Scoreboard bench for dsram_responder: two instances (L=2/Q=4 and L=4/Q=2).
module tb_dsram_responder;
  import dsram_pkg::*;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  dsram_responder_if b0();
  dsram_responder_if b1();

  dsram_responder #(.ADDR_W(10), .LATENCY(2), .QDEPTH(4)) u0 (
    .clk(clk), .resetn(resetn), .bus(b0));
  dsram_responder #(.ADDR_W(10), .LATENCY(4), .QDEPTH(2)) u1 (
    .clk(clk), .resetn(resetn), .bus(b1));

  typedef struct {
    logic [31:0] rdata;
    int          due;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;
  logic mon_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic drive(input int d, input logic rq, input logic w, input logic [3:0] strb,
                       input logic [31:0] a, input logic [31:0] wd);
    if (d == 0) begin
      b0.req = rq; b0.wr = w; b0.wstrb = strb; b0.addr = a; b0.wdata = wd;
      b0.size = (strb == 4'hF) ? SZ_WORD : SZ_BYTE;
    end else begin
      b1.req = rq; b1.wr = w; b1.wstrb = strb; b1.addr = a; b1.wdata = wd;
      b1.size = (strb == 4'hF) ? SZ_WORD : SZ_BYTE;
    end
  endtask

  // Called at a negedge; holds req until accepted, records the expected response.
  task automatic issue(input int d, input logic w, input logic [3:0] strb, input logic [31:0] a,
                       input logic [31:0] wd, input logic [31:0] exp_rd, output int waits);
    exp_t e;
    logic ok;
    int   lat;
    lat   = (d == 0) ? 2 : 4;
    waits = 0;
    drive(d, 1'b1, w, strb, a, wd);
    forever begin
      #1;
      ok = (d == 0) ? b0.addr_ok : b1.addr_ok;
      if (ok || waits >= 50) break;
      waits++;
      @(negedge clk);
    end
    if (!ok) begin
      chk($sformatf("issue_timeout dut%0d", d), {31'd0, ok}, 32'd1);
    end else begin
      e.rdata = w ? 32'h0 : exp_rd;
      e.due   = cyc + lat;
      if (d == 0) q0.push_back(e); else q1.push_back(e);
    end
    @(negedge clk);
    drive(d, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
  endtask

  task automatic check_resp(input int d);
    exp_t        e;
    logic [31:0] got;
    int          n;
    got = (d == 0) ? b0.rdata : b1.rdata;
    n   = (d == 0) ? q0.size() : q1.size();
    if (n == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_data_ok dut%0d: got rdata %h expected no pulse", d, got);
    end else begin
      if (d == 0) e = q0.pop_front(); else e = q1.pop_front();
      chk($sformatf("rdata dut%0d", d), got, e.rdata);
      chk($sformatf("resp_cycle dut%0d", d), cyc, e.due);
    end
  endtask

  // Monitor: every data_ok pulse is matched against the head expectation.
  initial begin
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (b0.data_ok) check_resp(0);
        if (b1.data_ok) check_resp(1);
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int w;
    resetn = 1'b0;
    drive(0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    drive(1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    mon_en = 1'b1;
    chk("reset addr_ok u0", {31'd0, b0.addr_ok}, 32'd1);
    chk("reset data_ok u0", {31'd0, b0.data_ok}, 32'd0);
    chk("reset rdata u0", b0.rdata, 32'h0);
    chk("reset addr_ok u1", {31'd0, b1.addr_ok}, 32'd1);
    chk("reset data_ok u1", {31'd0, b1.data_ok}, 32'd0);

    // Word write then read-after-write of 0x40.
    issue(0, 1'b1, 4'hF, 32'h40, 32'hDEADBEEF, 32'h0, w);
    issue(0, 1'b0, 4'h0, 32'h40, 32'h0, 32'hDEADBEEF, w);
    idle(4);

    // Byte lane 1 merge.
    issue(0, 1'b1, 4'hF, 32'h40, 32'h11223344, 32'h0, w);
    issue(0, 1'b1, 4'b0010, 32'h41, 32'h0000AA00, 32'h0, w);
    issue(0, 1'b0, 4'h0, 32'h40, 32'h0, 32'h1122AA44, w);
    idle(4);

    // Fill 0x00..0x1C, then eight back-to-back reads with no stall.
    for (int i = 0; i < 8; i++)
      issue(0, 1'b1, 4'hF, 32'(i * 4), 32'hA5000000 | 32'(i), 32'h0, w);
    idle(4);
    for (int i = 0; i < 8; i++) begin
      issue(0, 1'b0, 4'h0, 32'(i * 4), 32'h0, 32'hA5000000 | 32'(i), w);
      chk($sformatf("burst_stall %0d", i), 32'(w), 32'd0);
    end
    idle(5);

    // wstrb=0 write still responds and leaves memory alone.
    issue(0, 1'b1, 4'hF, 32'h80, 32'h55AA55AA, 32'h0, w);
    issue(0, 1'b1, 4'h0, 32'h80, 32'hFFFFFFFF, 32'h0, w);
    issue(0, 1'b0, 4'h0, 32'h80, 32'h0, 32'h55AA55AA, w);
    idle(4);

    // Reset with reads in flight: the last one must never be answered.
    issue(0, 1'b0, 4'h0, 32'h40, 32'h0, 32'h1122AA44, w);
    issue(0, 1'b0, 4'h0, 32'h00, 32'h0, 32'hA5000000, w);
    issue(0, 1'b0, 4'h0, 32'h80, 32'h0, 32'h55AA55AA, w);
    resetn = 1'b0;
    @(posedge clk);
    #1;
    q0.delete();
    q1.delete();
    @(negedge clk);
    resetn = 1'b1;
    chk("post_reset addr_ok u0", {31'd0, b0.addr_ok}, 32'd1);
    chk("post_reset data_ok u0", {31'd0, b0.data_ok}, 32'd0);
    idle(6);
    issue(0, 1'b0, 4'h0, 32'h40, 32'h0, 32'h1122AA44, w);
    issue(0, 1'b0, 4'h0, 32'h1C, 32'h0, 32'hA5000007, w);
    idle(4);

    // QDEPTH=2, LATENCY=4: backpressure after two acceptances.
    for (int i = 0; i < 5; i++)
      issue(1, 1'b1, 4'hF, 32'h100 + 32'(i * 4), 32'hC0DE0000 | 32'(i), 32'h0, w);
    idle(10);
    issue(1, 1'b0, 4'h0, 32'h100, 32'h0, 32'hC0DE0000, w);
    chk("u1 wait r0", 32'(w), 32'd0);
    issue(1, 1'b0, 4'h0, 32'h104, 32'h0, 32'hC0DE0001, w);
    chk("u1 wait r1", 32'(w), 32'd0);
    issue(1, 1'b0, 4'h0, 32'h108, 32'h0, 32'hC0DE0002, w);
    chk("u1 wait r2", 32'(w), 32'd3);
    issue(1, 1'b0, 4'h0, 32'h10C, 32'h0, 32'hC0DE0003, w);
    issue(1, 1'b0, 4'h0, 32'h110, 32'h0, 32'hC0DE0004, w);
    idle(12);

    chk("q0_drained", 32'(q0.size()), 32'd0);
    chk("q1_drained", 32'(q1.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
